// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a CPU (master 0) and a loader (master 1) onto one memory port.
// Build option: define ARB_ROUND_ROBIN_EN to alternate priority on simultaneous requests.
module mem_arbiter (
  input  logic        clk,
  input  logic        resn,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_instr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_addr,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_instr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_addr,
  output logic [31:0] m1_rdata,

  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_instr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,

  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT0 = 2'd1;
  localparam logic [1:0] S_GRANT1 = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       m0_wins;

`ifdef ARB_ROUND_ROBIN_EN
  // Master 0 wins a tie only when master 1 was served last.
  assign m0_wins = last_grant_q;
`else
  assign m0_wins = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (m0_valid && m1_valid) state_d = m0_wins ? S_GRANT0 : S_GRANT1;
        else if (m0_valid)        state_d = S_GRANT0;
        else if (m1_valid)        state_d = S_GRANT1;
      end
      S_GRANT0: begin
        // A withdrawn request aborts without crediting the master.
        if (!m0_valid) begin
          state_d = S_IDLE;
        end else if (mem_ready) begin
          state_d      = S_IDLE;
          last_grant_d = 1'b0;
        end
      end
      S_GRANT1: begin
        if (!m1_valid) begin
          state_d = S_IDLE;
        end else if (mem_ready) begin
          state_d      = S_IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Request fields are a pure mux on the registered state so reset drops them at once.
  always_comb begin
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_wstrb = 4'd0;
    mem_wdata = 32'd0;
    mem_addr  = 32'd0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    case (state_q)
      S_GRANT0: begin
        mem_valid = m0_valid;
        mem_instr = m0_instr;
        mem_wstrb = m0_wstrb;
        mem_wdata = m0_wdata;
        mem_addr  = m0_addr;
        m0_ready  = mem_ready;
      end
      S_GRANT1: begin
        mem_valid = m1_valid;
        mem_instr = m1_instr;
        mem_wstrb = m1_wstrb;
        mem_wdata = m1_wdata;
        mem_addr  = m1_addr;
        m1_ready  = mem_ready;
      end
      default: ;
    endcase
  end

  assign m0_rdata    = mem_rdata;
  assign m1_rdata    = mem_rdata;
  assign dbg_state_o = state_q;

endmodule
